brick_collider: RTL and testbench



---
 rtl/brick_collider.sv | 109 ++++++++++
 tb/tb_brick_collider.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/brick_collider.sv
// rtl/brick_collider.sv - per-frame ball/brick collision engine driving the renderer erase interface
module brick_collider #(
    parameter int BALL_SIZE       = 7,
    parameter int BLOCK_SPACING_X = 40,
    parameter int BLOCK_WIDTH     = 80,
    parameter int BLOCK_HEIGHT    = 30,
    parameter int FIRST_ROW_Y     = 40,
    parameter int SECOND_ROW_Y    = 90,
    parameter int SCAN_LINE       = 480
) (
    input  logic       CLK_25MH,
    input  logic       reset,
    input  logic [9:0] hor_count,
    input  logic [9:0] ver_count,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       erase_enable,
    output logic [5:0] erase_pos,
    output logic       bounce,
    output logic [3:0] blocks_left,
    output logic       all_cleared
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ERASE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  hit_idx;
    logic [9:0]  active;
    logic [9:0]  lat_x;
    logic [9:0]  lat_y;

    logic        start;
    logic        hit;
    logic [3:0]  col;
    logic [10:0] brick_x;
    logic [10:0] brick_y;
    logic [10:0] ball_l;
    logic [10:0] ball_t;

    assign start       = (hor_count == 10'd0) && (ver_count == 10'(SCAN_LINE)) && (blocks_left != 4'd0);
    assign all_cleared = (blocks_left == 4'd0);

    // 11-bit compares keep a ball near x=1023 from wrapping onto low bricks
    always_comb begin
        col     = (idx >= 4'd5) ? (idx - 4'd5) : idx;
        brick_x = 11'(BLOCK_SPACING_X) + 11'(BLOCK_SPACING_X + BLOCK_WIDTH) * {7'd0, col};
        brick_y = (idx < 4'd5) ? 11'(FIRST_ROW_Y) : 11'(SECOND_ROW_Y);
        ball_l  = {1'b0, lat_x};
        ball_t  = {1'b0, lat_y};
        hit     = (ball_l <= brick_x + 11'(BLOCK_WIDTH)) &&
                  (ball_l + 11'(BALL_SIZE) >= brick_x) &&
                  (ball_t <= brick_y + 11'(BLOCK_HEIGHT)) &&
                  (ball_t + 11'(BALL_SIZE) >= brick_y) &&
                  active[idx];
    end

    always_ff @(posedge CLK_25MH or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 4'd0;
            hit_idx      <= 4'd0;
            active       <= 10'h3FF;
            blocks_left  <= 4'd10;
            lat_x        <= 10'd0;
            lat_y        <= 10'd0;
            erase_enable <= 1'b0;
            erase_pos    <= 6'd0;
            bounce       <= 1'b0;
        end else begin
            erase_enable <= 1'b0;
            bounce       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_x <= ball_x;
                        lat_y <= ball_y;
                        idx   <= 4'd0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        hit_idx      <= idx;
                        erase_enable <= 1'b1;
                        bounce       <= 1'b1;
                        erase_pos    <= {2'b00, idx};
                        state        <= ERASE;
                    end else if (idx == 4'd9) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ERASE: begin
                    active[hit_idx] <= 1'b0;
                    blocks_left     <= blocks_left - 4'd1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brick_collider.sv
// tb/tb_brick_collider.sv - randomized frame-level bench for brick_collider
module tb_brick_collider;

    logic       CLK_25MH = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] hor_count = 10'd5;
    logic [9:0] ver_count = 10'd100;
    logic [9:0] ball_x    = 10'd0;
    logic [9:0] ball_y    = 10'd0;
    logic       erase_enable;
    logic [5:0] erase_pos;
    logic       bounce;
    logic [3:0] blocks_left;
    logic       all_cleared;

    int total = 0;
    int bad   = 0;

    bit m_active[10];
    int m_count;
    int m_last_pos;

    brick_collider dut (
        .CLK_25MH    (CLK_25MH),
        .reset       (reset),
        .hor_count   (hor_count),
        .ver_count   (ver_count),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .erase_enable(erase_enable),
        .erase_pos   (erase_pos),
        .bounce      (bounce),
        .blocks_left (blocks_left),
        .all_cleared (all_cleared)
    );

    always #20 CLK_25MH = ~CLK_25MH;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int brick_x(input int i);
        return 40 + 120 * (i % 5);
    endfunction

    function automatic int brick_y(input int i);
        return (i < 5) ? 40 : 90;
    endfunction

    function automatic int model_hit(input int x, input int y);
        if (m_count == 0) return -1;
        for (int i = 0; i < 10; i++) begin
            if (m_active[i] && x <= brick_x(i) + 80 && x + 7 >= brick_x(i) &&
                y <= brick_y(i) + 30 && y + 7 >= brick_y(i))
                return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_active[i] = 1'b1;
        m_count    = 10;
        m_last_pos = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK_25MH);
        reset = 1'b1;
        repeat (2) @(negedge CLK_25MH);
        reset = 1'b0;
        model_reset();
    endtask

    // one blanking-line start pulse; jitter holds the start for a second edge
    // (must be ignored mid-scan) and moves the ball after the latch
    task automatic run_frame(input int x, input int y, input bit jitter);
        int exp_hit;
        int got_pos;
        int got_cyc;
        int n_er;
        int bounce_bad;
        exp_hit    = model_hit(x, y);
        got_pos    = -1;
        got_cyc    = -1;
        n_er       = 0;
        bounce_bad = 0;
        if (exp_hit >= 0) begin
            m_active[exp_hit] = 1'b0;
            m_count--;
            m_last_pos = exp_hit;
        end
        @(negedge CLK_25MH);
        ball_x    = 10'(x);
        ball_y    = 10'(y);
        hor_count = 10'd0;
        ver_count = 10'd480;
        @(posedge CLK_25MH);
        @(negedge CLK_25MH);
        if (jitter) begin
            ball_x = 10'($urandom_range(0, 1023));
            ball_y = 10'($urandom_range(0, 1023));
        end else begin
            ver_count = 10'd100;
            hor_count = 10'd5;
        end
        for (int c = 1; c <= 13; c++) begin
            @(posedge CLK_25MH);
            #1;
            if (c == 1) begin
                ver_count = 10'd100;
                hor_count = 10'd5;
            end
            if (got_cyc > 0 && c == got_cyc) begin
                chk("blocks_left_after", blocks_left, m_count);
                chk("all_cleared_after", all_cleared, (m_count == 0));
            end
            if (erase_enable === 1'b1) begin
                n_er++;
                got_pos = erase_pos;
                got_cyc = c + 1;
            end
            if (bounce !== erase_enable) bounce_bad++;
        end
        chk("erase_count", n_er, (exp_hit >= 0) ? 1 : 0);
        if (exp_hit >= 0) begin
            chk("erase_pos", got_pos, exp_hit);
            chk("erase_latency", got_cyc, exp_hit + 2);
        end
        chk("bounce_match", bounce_bad, 0);
        chk("erase_pos_hold", erase_pos, m_last_pos);
        chk("blocks_left", blocks_left, m_count);
        chk("all_cleared", all_cleared, (m_count == 0));
    endtask

    initial begin
        int x;
        int y;
        int k;
        int guard;
        bit seen;

        model_reset();
        repeat (2) @(negedge CLK_25MH);
        #1;
        chk("rst_erase_enable", erase_enable, 0);
        chk("rst_erase_pos", erase_pos, 0);
        chk("rst_bounce", bounce, 0);
        chk("rst_blocks_left", blocks_left, 10);
        chk("rst_all_cleared", all_cleared, 0);
        reset = 1'b0;

        run_frame(33, 33, 0);
        do_reset();
        run_frame(32, 33, 0);
        do_reset();
        for (int f = 0; f < 3; f++) run_frame(0, 300, 0);
        run_frame(100, 50, 0);
        run_frame(100, 50, 0);
        run_frame(513, 83, 0);
        run_frame(153, 65, 0);
        run_frame(1023, 1023, 0);
        run_frame(1023, 40, 1);

        do_reset();
        for (int f = 0; f < 60; f++) begin
            if (f % 15 == 0) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end else begin
                k = $urandom_range(0, 9);
                x = brick_x(k) - 12 + $urandom_range(0, 104);
                y = brick_y(k) - 12 + $urandom_range(0, 54);
            end
            run_frame(x, y, ($urandom_range(0, 1) == 1));
        end

        do_reset();
        guard = 0;
        while (m_count > 0 && guard < 20) begin
            k = -1;
            for (int i = 9; i >= 0; i--) if (m_active[i]) k = i;
            run_frame(brick_x(k) + 10, brick_y(k) + 10, 0);
            guard++;
        end
        chk("clear_all_done", m_count, 0);
        run_frame(100, 50, 0);
        run_frame(520, 90, 0);

        do_reset();
        @(negedge CLK_25MH);
        ball_x    = 10'd100;
        ball_y    = 10'd50;
        hor_count = 10'd0;
        ver_count = 10'd480;
        @(negedge CLK_25MH);
        ver_count = 10'd100;
        hor_count = 10'd5;
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(posedge CLK_25MH);
            #1;
            if (erase_enable === 1'b1) seen = 1'b1;
        end
        chk("erase_before_reset", seen, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_erase_enable", erase_enable, 0);
        chk("async_rst_bounce", bounce, 0);
        chk("async_rst_erase_pos", erase_pos, 0);
        chk("async_rst_blocks_left", blocks_left, 10);
        chk("async_rst_all_cleared", all_cleared, 0);
        @(negedge CLK_25MH);
        reset = 1'b0;
        model_reset();
        run_frame(100, 50, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
